// File: rtl/elevator_controller.sv
// Sequencing FSM for an 8-floor single-car elevator: latches calls, picks a
// direction by the above/below pending-call rule and steps the car on a timer.
module elevator_controller #(
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3,
  parameter int TIMER_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] call_req,
  output logic [2:0] floor,
  output logic       door_open,
  output logic       moving_up,
  output logic       moving_down,
  output logic [7:0] calls_pending,
  output logic       arrived
);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  localparam logic [TIMER_W-1:0] FLOOR_LOAD = TIMER_W'(FLOOR_TICKS - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD  = TIMER_W'(DOOR_TICKS - 1);

  state_t             state, state_nx;
  logic [2:0]         floor_nx, step_floor;
  logic [7:0]         calls, calls_nx, clr, req_eff;
  logic [7:0]         above, below, beyond;
  logic [3:0]         n_above, n_below;
  logic [TIMER_W-1:0] timer, timer_nx;
  logic               dir, dir_nx, dir_valid, dir_valid_nx, arrived_nx;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Pending calls split around the car, and the floor one step ahead in dir.
  always_comb begin
    above      = '0;
    below      = '0;
    beyond     = '0;
    step_floor = floor;
    if (dir && floor != 3'd7)
      step_floor = floor + 3'd1;
    else if (!dir && floor != 3'd0)
      step_floor = floor - 3'd1;
    for (int i = 0; i < 8; i++) begin
      above[i]  = calls[i] && (3'(i) > floor);
      below[i]  = calls[i] && (3'(i) < floor);
      beyond[i] = calls[i] && (dir ? (3'(i) > step_floor) : (3'(i) < step_floor));
    end
    n_above = count_ones(above);
    n_below = count_ones(below);
  end

  always_comb begin
    state_nx     = state;
    floor_nx     = floor;
    timer_nx     = timer;
    dir_nx       = dir;
    dir_valid_nx = dir_valid;
    arrived_nx   = 1'b0;
    clr          = '0;
    req_eff      = call_req;
    case (state)
      IDLE: begin
        // A call for the floor the car already sits at opens the door at once.
        if (calls[floor] || call_req[floor]) begin
          state_nx   = DOOR;
          timer_nx   = DOOR_LOAD;
          clr[floor] = 1'b1;
        end else if ((above | below) != 8'd0) begin
          if (dir_valid)
            dir_nx = dir ? (above != 8'd0) : (below == 8'd0);
          else
            dir_nx = (n_above >= n_below);
          dir_valid_nx = 1'b1;
          state_nx     = MOVE;
          timer_nx     = FLOOR_LOAD;
        end
      end
      MOVE: begin
        if (timer != '0) begin
          timer_nx = timer - TIMER_W'(1);
        end else begin
          floor_nx   = step_floor;
          arrived_nx = (step_floor != floor);
          if (calls[step_floor]) begin
            state_nx        = DOOR;
            timer_nx        = DOOR_LOAD;
            clr[step_floor] = 1'b1;
          end else if (beyond != 8'd0) begin
            timer_nx = FLOOR_LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DOOR: begin
        // Pressing the current floor again holds the door instead of queueing.
        if (call_req[floor]) begin
          req_eff[floor] = 1'b0;
          timer_nx       = DOOR_LOAD;
        end else if (timer != '0) begin
          timer_nx = timer - TIMER_W'(1);
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    calls_nx = (calls | req_eff) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      floor     <= 3'd0;
      calls     <= 8'd0;
      timer     <= '0;
      dir       <= 1'b1;
      dir_valid <= 1'b0;
      arrived   <= 1'b0;
    end else begin
      state     <= state_nx;
      floor     <= floor_nx;
      calls     <= calls_nx;
      timer     <= timer_nx;
      dir       <= dir_nx;
      dir_valid <= dir_valid_nx;
      arrived   <= arrived_nx;
    end
  end

  assign door_open     = (state == DOOR);
  assign moving_up     = (state == MOVE) && dir;
  assign moving_down   = (state == MOVE) && !dir;
  assign calls_pending = calls;

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench for elevator_controller: directed scenarios plus random
// calls compared every cycle against a floor/phase-level reference model.
module tb_elevator_controller;

  localparam int FLOOR_TICKS = 4;
  localparam int DOOR_TICKS  = 3;
  localparam int PH_IDLE = 0, PH_TRAVEL = 1, PH_DOOR = 2;

  logic       clk;
  logic       reset;
  logic [7:0] call_req;
  logic [2:0] floor;
  logic       door_open, moving_up, moving_down, arrived;
  logic [7:0] calls_pending;

  int total = 0;
  int bad   = 0;

  int       m_phase, m_left, m_floor;
  bit       m_up, m_have_dir, m_arrived;
  bit [7:0] m_pend;

  elevator_controller #(.FLOOR_TICKS(FLOOR_TICKS), .DOOR_TICKS(DOOR_TICKS), .TIMER_W(8)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .floor(floor),
    .door_open(door_open), .moving_up(moving_up), .moving_down(moving_down),
    .calls_pending(calls_pending), .arrived(arrived)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int count_range(input bit [7:0] p, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (i >= 0 && i < 8 && p[i]) n++;
    return n;
  endfunction

  // Reference: car phase, cycles left in the phase, floor as an integer.
  task automatic model_edge(input bit rst, input bit [7:0] req);
    bit [7:0] nxt;
    int ups, downs;
    if (rst) begin
      m_phase = PH_IDLE; m_left = 0; m_floor = 0; m_up = 1; m_have_dir = 0;
      m_pend = 0; m_arrived = 0;
      return;
    end
    nxt = m_pend | req;
    m_arrived = 0;
    case (m_phase)
      PH_IDLE: begin
        if (m_pend[m_floor] || req[m_floor]) begin
          m_phase = PH_DOOR; m_left = DOOR_TICKS; nxt[m_floor] = 0;
        end else begin
          ups   = count_range(m_pend, m_floor + 1, 7);
          downs = count_range(m_pend, 0, m_floor - 1);
          if (ups + downs > 0) begin
            if (m_have_dir) m_up = m_up ? (ups > 0) : (downs == 0);
            else m_up = (ups >= downs);
            m_have_dir = 1; m_phase = PH_TRAVEL; m_left = FLOOR_TICKS;
          end
        end
      end
      PH_TRAVEL: begin
        if (m_left > 1) m_left--;
        else begin
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          m_arrived = 1;
          if (m_pend[m_floor]) begin
            m_phase = PH_DOOR; m_left = DOOR_TICKS; nxt[m_floor] = 0;
          end else if ((m_up ? count_range(m_pend, m_floor + 1, 7)
                             : count_range(m_pend, 0, m_floor - 1)) > 0)
            m_left = FLOOR_TICKS;
          else
            m_phase = PH_IDLE;
        end
      end
      default: begin
        if (req[m_floor]) begin
          nxt[m_floor] = m_pend[m_floor]; m_left = DOOR_TICKS;
        end else if (m_left > 1) m_left--;
        else m_phase = PH_IDLE;
      end
    endcase
    m_pend = nxt;
  endtask

  function automatic logic [14:0] observed();
    return {floor, door_open, moving_up, moving_down, arrived, calls_pending};
  endfunction

  function automatic logic [14:0] expected();
    return {3'(m_floor), m_phase == PH_DOOR, m_phase == PH_TRAVEL && m_up,
            m_phase == PH_TRAVEL && !m_up, m_arrived, m_pend};
  endfunction

  task automatic applyStimulus(input bit rst, input logic [7:0] req);
    reset = rst;
    call_req = req;
    @(posedge clk);
    model_edge(rst, req);
    #1;
    checkOutput("cycle", 32'(observed()), 32'(expected()));
  endtask

  initial begin
    int k, first_door, second_door, n_doors;
    bit prev_door, rst;
    logic [7:0] req;

    reset = 1'b1;
    call_req = 8'd0;
    applyStimulus(1, 8'd0);
    applyStimulus(1, 8'd0);
    checkOutput("reset_state", 32'(observed()), 32'd0);

    // Single call to floor 2 from reset.
    applyStimulus(0, 8'h04);
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(0, 8'd0);
      if (j == 1)  checkOutput("t1_up", 32'(moving_up), 32'd1);
      if (j == 5)  checkOutput("t1_floor1", 32'({floor, arrived}), 32'({3'd1, 1'b1}));
      if (j == 9)  checkOutput("t1_floor2_door", 32'({floor, door_open, arrived, calls_pending}),
                               32'({3'd2, 1'b1, 1'b1, 8'd0}));
      if (j == 11) checkOutput("t1_door_last", 32'(door_open), 32'd1);
      if (j == 12) checkOutput("t1_door_closed", 32'(door_open), 32'd0);
    end

    // Call from the current floor while idle.
    applyStimulus(0, 8'h08);
    for (k = 0; k < 40 && !(m_phase == PH_IDLE && m_pend == 0); k++) applyStimulus(0, 8'd0);
    checkOutput("t2_at_floor3", 32'(floor), 32'd3);
    applyStimulus(0, 8'h08);
    checkOutput("t2_door_now", 32'({door_open, moving_up, moving_down, calls_pending}),
                32'({1'b1, 1'b0, 1'b0, 8'd0}));

    // SCAN: serve 5 on the way up before reversing to 0.
    applyStimulus(1, 8'd0);
    applyStimulus(0, 8'h20);
    for (k = 0; k < 30 && m_floor != 2; k++) applyStimulus(0, 8'd0);
    checkOutput("t4_reach2", 32'(floor), 32'd2);
    applyStimulus(0, 8'h01);
    n_doors = 0; first_door = -1; second_door = -1; prev_door = 0;
    for (k = 0; k < 120 && n_doors < 2; k++) begin
      applyStimulus(0, 8'd0);
      if (door_open && !prev_door) begin
        if (n_doors == 0) first_door = int'(floor);
        else second_door = int'(floor);
        n_doors++;
      end
      prev_door = door_open;
    end
    checkOutput("t4_first_stop", 32'(first_door), 32'd5);
    checkOutput("t4_second_stop", 32'(second_door), 32'd0);

    // Reset while moving.
    applyStimulus(1, 8'd0);
    applyStimulus(0, 8'h80);
    for (k = 0; k < 40 && !(m_floor == 3 && m_phase == PH_TRAVEL); k++) applyStimulus(0, 8'd0);
    checkOutput("t5_mid_move", 32'({floor, moving_up}), 32'({3'd3, 1'b1}));
    applyStimulus(1, 8'd0);
    checkOutput("t5_reset", 32'(observed()), 32'd0);

    // Re-press of the open-door floor on its last cycle.
    applyStimulus(0, 8'h40);
    for (k = 0; k < 60 && !(m_phase == PH_DOOR && m_left == 1); k++) applyStimulus(0, 8'd0);
    checkOutput("t6_door_at6", 32'({floor, door_open}), 32'({3'd6, 1'b1}));
    applyStimulus(0, 8'h40);
    checkOutput("t6_hold", 32'({door_open, calls_pending[6]}), 32'({1'b1, 1'b0}));
    for (int j = 1; j <= 3; j++) begin
      applyStimulus(0, 8'd0);
      checkOutput("t6_door", 32'({door_open, calls_pending[6]}), 32'({(j < 3), 1'b0}));
    end

    // Random calls, occasional multi-bit bursts and resets.
    applyStimulus(1, 8'd0);
    for (int j = 0; j < 1500; j++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 5) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
      if ($urandom_range(0, 39) == 0) req = 8'($urandom);
      applyStimulus(rst, req);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
